// File: rtl/softex_fp_vec_pack.sv
// Packs a scalar FP element stream into N_INP-lane vectors with per-lane strobes.
// One cycle from the completing handshake to valid_o; one pending vector stalls the input.
module softex_fp_vec_pack #(
  parameter int unsigned FPFORMAT     = 0,
  parameter int unsigned FPFORMAT_ACC = 0,
  parameter int unsigned N_INP        = 4,
  parameter type         TAG_TYPE     = logic,
  localparam int unsigned WIDTH =
    (FPFORMAT == 1) ? 64 :
    ((FPFORMAT == 2) || (FPFORMAT == 4)) ? 16 :
    ((FPFORMAT == 3) || (FPFORMAT == 5)) ? 8 : 32,
  localparam int unsigned ACC_WIDTH =
    (FPFORMAT_ACC == 1) ? 64 :
    ((FPFORMAT_ACC == 2) || (FPFORMAT_ACC == 4)) ? 16 :
    ((FPFORMAT_ACC == 3) || (FPFORMAT_ACC == 5)) ? 8 : 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        last_i,
  input  TAG_TYPE                     tag_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [N_INP-1:0][WIDTH-1:0] op_o,
  output logic [N_INP-1:0]            strb_o,
  output TAG_TYPE                     tag_o,
  output logic                        busy_o
);

  localparam int unsigned CW = (N_INP > 1) ? $clog2(N_INP) : 1;
  localparam logic [CW-1:0] LAST_LANE = CW'(N_INP - 1);

  if (N_INP < 1) begin : g_bad_ninp
    $error("softex_fp_vec_pack: N_INP must be >= 1");
  end
  if (ACC_WIDTH < WIDTH) begin : g_bad_acc
    $error("softex_fp_vec_pack: accumulator format narrower than element format");
  end

  typedef logic [N_INP-1:0][WIDTH-1:0] vec_t;

  vec_t             fill_op_q, fill_op_d, merge_op, out_op_q, out_op_d;
  logic [N_INP-1:0] fill_strb_q, fill_strb_d, merge_strb, out_strb_q, out_strb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  TAG_TYPE          fill_tag_q, fill_tag_d, merge_tag, out_tag_q, out_tag_d;
  logic             pend_q, pend_d, out_vld_q, out_vld_d;
  logic             in_hs, out_hs, slot_free, complete;

  assign ready_o   = ~pend_q;
  assign valid_o   = out_vld_q;
  assign op_o      = out_op_q;
  assign strb_o    = out_strb_q;
  assign tag_o     = out_tag_q;
  assign busy_o    = (cnt_q != '0) | pend_q | out_vld_q;

  assign in_hs     = valid_i & ready_o;
  assign out_hs    = out_vld_q & ready_i;
  assign slot_free = ~out_vld_q | ready_i;
  assign complete  = in_hs & ((cnt_q == LAST_LANE) | last_i);

  // Fill contents with the incoming element folded into lane cnt.
  always_comb begin
    merge_op   = fill_op_q;
    merge_strb = fill_strb_q;
    for (int k = 0; k < N_INP; k++) begin
      if (cnt_q == CW'(k)) begin
        merge_op[k]   = data_i;
        merge_strb[k] = 1'b1;
      end
    end
    merge_tag = (cnt_q == '0) ? tag_i : fill_tag_q;
  end

  always_comb begin
    fill_op_d   = fill_op_q;
    fill_strb_d = fill_strb_q;
    fill_tag_d  = fill_tag_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    out_op_d    = out_op_q;
    out_strb_d  = out_strb_q;
    out_tag_d   = out_tag_q;
    out_vld_d   = out_hs ? 1'b0 : out_vld_q;

    if (clear_i) begin
      fill_op_d   = '0;
      fill_strb_d = '0;
      cnt_d       = '0;
      pend_d      = 1'b0;
      out_op_d    = '0;
      out_strb_d  = '0;
      out_vld_d   = 1'b0;
    end else if (pend_q) begin
      // Input is stalled; the held vector moves out as soon as the slot frees.
      if (out_hs) begin
        out_op_d    = fill_op_q;
        out_strb_d  = fill_strb_q;
        out_tag_d   = fill_tag_q;
        out_vld_d   = 1'b1;
        fill_op_d   = '0;
        fill_strb_d = '0;
        cnt_d       = '0;
        pend_d      = 1'b0;
      end
    end else if (in_hs) begin
      if (complete && slot_free) begin
        out_op_d    = merge_op;
        out_strb_d  = merge_strb;
        out_tag_d   = merge_tag;
        out_vld_d   = 1'b1;
        fill_op_d   = '0;
        fill_strb_d = '0;
        cnt_d       = '0;
      end else begin
        fill_op_d   = merge_op;
        fill_strb_d = merge_strb;
        fill_tag_d  = merge_tag;
        if (complete) begin
          pend_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fill_op_q   <= '0;
      fill_strb_q <= '0;
      fill_tag_q  <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      out_op_q    <= '0;
      out_strb_q  <= '0;
      out_tag_q   <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      fill_op_q   <= fill_op_d;
      fill_strb_q <= fill_strb_d;
      fill_tag_q  <= fill_tag_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      out_op_q    <= out_op_d;
      out_strb_q  <= out_strb_d;
      out_tag_q   <= out_tag_d;
      out_vld_q   <= out_vld_d;
    end
  end

endmodule
